pic_init_sequencer: RTL

Initialisation and command-word sequencer for the 8259A PIC. It sits directly behind `Bus_Control_Logic`, consuming the buffered write level, A0 and the internal data bus. It steps through the ICW1→ICW2→[ICW3]→[ICW4] programming sequence, then routes A0/D4/D3-qualified writes to OCW1/OCW2/OCW3. It holds every programmed configuration field as registered outputs for the priority resolver, IRR/ISR and cascade blocks.

---
 rtl/pic_init_sequencer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pic_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pic_init_sequencer
// Purpose  : 8259A initialisation / command-word sequencer. Captures bus
//            writes from the bus control logic, accepts each one when the
//            write level is released, steps ICW1 -> ICW2 -> [ICW3] -> [ICW4]
//            and then routes OCW1/OCW2/OCW3. Every programmed field is held
//            in a register for the priority, IRR/ISR and cascade blocks.
// Ports    : clock, reset (sync, active-high)
//            write_enable, address (A0), internal_data_bus[7:0]  - bus side
//            init_done, icw1_strobe, level_triggered, single_mode,
//            vector_base[4:0], cascade_config[7:0], auto_eoi, upm_8086,
//            buffered_mode, buffered_master, special_fully_nested,
//            interrupt_mask[7:0], ocw2_strobe, ocw2_command[7:0],
//            special_mask_mode, read_register_isr, poll_strobe
// Revision : 1.0 - initial release
// ============================================================================
module pic_init_sequencer (
    input  logic       clock,
    input  logic       reset,
    input  logic       write_enable,
    input  logic       address,
    input  logic [7:0] internal_data_bus,
    output logic       init_done,
    output logic       icw1_strobe,
    output logic       level_triggered,
    output logic       single_mode,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_config,
    output logic       auto_eoi,
    output logic       upm_8086,
    output logic       buffered_mode,
    output logic       buffered_master,
    output logic       special_fully_nested,
    output logic [7:0] interrupt_mask,
    output logic       ocw2_strobe,
    output logic [7:0] ocw2_command,
    output logic       special_mask_mode,
    output logic       read_register_isr,
    output logic       poll_strobe
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_WAIT_ICW2 = 3'd1;
    localparam logic [2:0] c_ST_WAIT_ICW3 = 3'd2;
    localparam logic [2:0] c_ST_WAIT_ICW4 = 3'd3;
    localparam logic [2:0] c_ST_READY     = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_state_next;

    // Write capture and release detection
    logic       r_we_d;
    logic       r_cap_a0;
    logic [7:0] r_cap_data;

    // Configuration registers
    logic       r_ic4;
    logic       r_ltim;
    logic       r_sngl;
    logic [4:0] r_vector_base;
    logic [7:0] r_cascade;
    logic [4:0] r_icw4;        // ICW4 D4:D0 as written
    logic [7:0] r_imr;
    logic [7:0] r_ocw2_cmd;
    logic       r_smm;
    logic       r_rr_isr;
    logic       r_icw1_strobe;
    logic       r_ocw2_strobe;
    logic       r_poll_strobe;

    logic w_accept;
    logic w_acc_icw1;
    logic w_acc_a0;
    logic w_acc_ocw2;
    logic w_acc_ocw3;

    // A write takes effect on the falling edge of the registered level, using
    // the values captured during the last high cycle.
    assign w_accept   = r_we_d & ~write_enable;
    assign w_acc_icw1 = w_accept & ~r_cap_a0 & r_cap_data[4];
    assign w_acc_a0   = w_accept & r_cap_a0;
    assign w_acc_ocw2 = w_accept & ~r_cap_a0 & ~r_cap_data[4] & ~r_cap_data[3]
                        & (r_state == c_ST_READY);
    assign w_acc_ocw3 = w_accept & ~r_cap_a0 & ~r_cap_data[4] & r_cap_data[3]
                        & (r_state == c_ST_READY);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_we_d     <= 1'b0;
            r_cap_a0   <= 1'b0;
            r_cap_data <= 8'h00;
        end else begin
            r_we_d <= write_enable;
            if (write_enable) begin
                r_cap_a0   <= address;
                r_cap_data <= internal_data_bus;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_acc_icw1) begin
            w_state_next = c_ST_WAIT_ICW2;
        end else if (w_acc_a0) begin
            case (r_state)
                c_ST_WAIT_ICW2: begin
                    if (!r_sngl)    w_state_next = c_ST_WAIT_ICW3;
                    else if (r_ic4) w_state_next = c_ST_WAIT_ICW4;
                    else            w_state_next = c_ST_READY;
                end
                c_ST_WAIT_ICW3: w_state_next = r_ic4 ? c_ST_WAIT_ICW4 : c_ST_READY;
                c_ST_WAIT_ICW4: w_state_next = c_ST_READY;
                default:        w_state_next = r_state;   // IDLE ignores, READY is OCW1
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ic4         <= 1'b0;
            r_ltim        <= 1'b0;
            r_sngl        <= 1'b0;
            r_vector_base <= 5'd0;
            r_cascade     <= 8'h00;
            r_icw4        <= 5'd0;
            r_imr         <= 8'h00;
            r_ocw2_cmd    <= 8'h00;
            r_smm         <= 1'b0;
            r_rr_isr      <= 1'b0;
            r_icw1_strobe <= 1'b0;
            r_ocw2_strobe <= 1'b0;
            r_poll_strobe <= 1'b0;
        end else begin
            r_icw1_strobe <= w_acc_icw1;
            r_ocw2_strobe <= w_acc_ocw2;
            r_poll_strobe <= w_acc_ocw3 & r_cap_data[2];

            if (w_acc_icw1) begin
                r_ltim   <= r_cap_data[3];
                r_sngl   <= r_cap_data[1];
                r_ic4    <= r_cap_data[0];
                r_imr    <= 8'h00;
                r_smm    <= 1'b0;
                r_rr_isr <= 1'b0;
                // Without an ICW4 the mode bits fall back to their defaults.
                if (!r_cap_data[0]) begin
                    r_icw4 <= 5'd0;
                end
            end else if (w_acc_a0) begin
                case (r_state)
                    c_ST_WAIT_ICW2: r_vector_base <= r_cap_data[7:3];
                    c_ST_WAIT_ICW3: r_cascade     <= r_cap_data;
                    c_ST_WAIT_ICW4: r_icw4        <= r_cap_data[4:0];
                    c_ST_READY:     r_imr         <= r_cap_data;
                    default:        r_imr         <= r_imr;
                endcase
            end

            if (w_acc_ocw2) begin
                r_ocw2_cmd <= r_cap_data;
            end

            if (w_acc_ocw3) begin
                if (r_cap_data[6]) r_smm    <= r_cap_data[5];
                if (r_cap_data[1]) r_rr_isr <= r_cap_data[0];
            end
        end
    end

    assign init_done            = (r_state == c_ST_READY);
    assign icw1_strobe          = r_icw1_strobe;
    assign level_triggered      = r_ltim;
    assign single_mode          = r_sngl;
    assign vector_base          = r_vector_base;
    assign cascade_config       = r_cascade;
    assign special_fully_nested = r_icw4[4];
    assign buffered_mode        = r_icw4[3];
    assign buffered_master      = r_icw4[2];
    assign auto_eoi             = r_icw4[1];
    assign upm_8086             = r_icw4[0];
    assign interrupt_mask       = r_imr;
    assign ocw2_strobe          = r_ocw2_strobe;
    assign ocw2_command         = r_ocw2_cmd;
    assign special_mask_mode    = r_smm;
    assign read_register_isr    = r_rr_isr;
    assign poll_strobe          = r_poll_strobe;

endmodule
`default_nettype wire
